mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-port memory request arbiter for the Hermes core.
- Generalises the separate fixed instruction/data memory interface pair into one block with NUM_PORTS CPU-side requesters (IM, DM, later DMA/debug).
- Grants one requester at a time, round-robin, onto the single request/ready memory port of the AXI memory interface.
- Returns read data, a per-port continue (stall release) and a timeout error.

Parameters:
- NUM_PORTS, 2, number of requesting ports (2..8).
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- TIMEOUT_CYCLES, 1024, max wait for memory response; 0 disables timeout.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- port_req  in  NUM_PORTS  per-port request level; held until the matching port_done.
- port_write  in  NUM_PORTS  1 = write, 0 = read.
- port_addr  in  NUM_PORTS*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W].
- port_wdata  in  NUM_PORTS*DATA_W  packed write data.
- port_size  in  NUM_PORTS*2  packed size select (00 byte, 01 half, 10 word, 11 double).
- port_done  out  NUM_PORTS  one-cycle completion pulse for the granted port.
- port_err  out  1  valid with port_done; 1 = timed out.
- port_rdata  out  DATA_W  read data, valid with port_done.
- port_continue  out  NUM_PORTS  bit i = ~port_req[i] | port_done[i]; combinational; feeds CPU PCContinue.
- mem_read_request  out  1  level read request to memory.
- mem_write_request  out  1  level write request to memory.
- mem_address  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_size  out  2  latched size.
- mem_read_ready  in  1  read complete, mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  memory read data.
- mem_write_finished  in  1  write complete.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, grant=0, mem_*_request=0, mem_address/wdata/size=0, port_done=0, port_err=0, port_rdata=0, timeout counter=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If any port_req is set, pick the first set bit scanning upward from rr_ptr, wrapping modulo NUM_PORTS.
  - Latch grant, addr, wdata, size and write bit; go to WAIT.
  - mem_read_request or mem_write_request rises on the next cycle.
- WAIT:
  - Request held high and latched fields held stable.
  - The counter increments each cycle.
  - Completion: mem_read_ready for a read, or mem_write_finished for a write. On completion, capture mem_rdata (reads; writes leave port_rdata = 0), set err=0, go to DONE.
  - Ignored in WAIT: the completion strobe for the wrong direction.
  - Timeout: counter == TIMEOUT_CYCLES-1 with no completion (only when TIMEOUT_CYCLES != 0) -> err=1, port_rdata=0, go to DONE.
  - Completion and timeout in the same cycle: completion wins, err=0.
- DONE:
  - mem requests low.
  - port_done[grant]=1 for exactly one cycle, with port_err and port_rdata valid.
  - rr_ptr = (grant+1) mod NUM_PORTS; counter cleared; go to IDLE.
  - port_rdata holds its value until the next DONE.
- Latency:
  - port_req seen in IDLE at cycle t -> mem request high at t+1.
  - Memory ready sampled at cycle u -> port_done at u+1.
  - Next grant decision at u+2.
  - Minimum per-transaction occupancy: 3 cycles.
- port_req for the granted port dropped during WAIT: the transaction completes normally and port_done still pulses.
- Other ports' requests are never lost; each waits, held, for its grant.
- A memory completion strobe outside WAIT is ignored.
- Reset asserted mid-transaction: all state returns to reset values at that edge; no port_done is issued for the aborted transaction.
- Fairness: with all ports requesting continuously, each port is granted once per NUM_PORTS transactions.

Test Plan:
- Single read: port 1 reads addr 0x1000, size 11; memory answers read_ready 4 cycles after request with 0xDEADBEEF_CAFEF00D -> mem_read_request high 1 cycle after req; port_done[1] at ready+1 with port_rdata = that value, port_err=0; mem_address=0x1000 throughout.
- Round-robin: NUM_PORTS=4, all ports request writes continuously, memory finishes in 1 cycle -> grant order 0,1,2,3,0,…; port_continue[i]=0 except on its done cycle.
- Timeout: TIMEOUT_CYCLES=8, port 0 read, memory silent -> port_done[0] with port_err=1 and port_rdata=0 after 8 WAIT cycles; the next request is serviced normally.
- Wrong strobe: a write is pending and mem_read_ready pulses -> ignored; completion occurs only on mem_write_finished.
- Simultaneous completion and timeout: ready arrives on the timeout cycle -> port_err=0, data captured.
- Reset mid-WAIT: assert reset during a read -> requests low and state IDLE next cycle; no port_done; a new request after reset is granted to port 0 first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter of NUM_PORTS CPU requesters onto one request/ready memory port
// Ports:
//    aclk, reset                      clock and synchronous active-high reset
//    port_req/write/addr/wdata/size   packed per-port requests, port i at slice i
//    port_done, port_err, port_rdata  one-cycle completion pulse for the granted port, timeout flag, read data
//    port_continue                    per-port stall release, ~port_req | port_done
//    mem_*                            level request with latched fields; ready/finished strobes back
module mem_port_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          aclk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          port_req,
   input  logic [NUM_PORTS-1:0]          port_write,
   input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
   input  logic [NUM_PORTS*2-1:0]        port_size,
   output logic [NUM_PORTS-1:0]          port_done,
   output logic                          port_err,
   output logic [DATA_W-1:0]             port_rdata,
   output logic [NUM_PORTS-1:0]          port_continue,
   output logic                          mem_read_request,
   output logic                          mem_write_request,
   output logic [ADDR_W-1:0]             mem_address,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic [1:0]                    mem_size,
   input  logic                          mem_read_ready,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_write_finished
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t state, state_nxt;
   logic [PW-1:0] rr_ptr, grant, pick, idx;
   logic [CW-1:0] cnt;
   logic wr, cmp, tmo;
   // scan downward in offset so the set bit closest above rr_ptr wins
   always_comb begin
      pick = '0;
      idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
         if (port_req[idx]) pick = idx;
      end
   end
   always_comb begin
      cmp = wr ? mem_write_finished : mem_read_ready;
      tmo = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
      state_nxt = state == IDLE ? (|port_req ? WAIT : IDLE) :
                  state == WAIT ? (cmp || tmo ? DONE : WAIT) : IDLE;
   end
   always_ff @(posedge aclk)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge aclk)
      if (reset) begin
         rr_ptr <= '0;
         grant <= '0;
         wr <= 1'b0;
         cnt <= '0;
         mem_address <= '0;
         mem_wdata <= '0;
         mem_size <= '0;
         port_err <= 1'b0;
         port_rdata <= '0;
      end else begin
         if (state == IDLE && |port_req) begin
            grant <= pick;
            wr <= port_write[pick];
            mem_address <= port_addr[pick*ADDR_W +: ADDR_W];
            mem_wdata <= port_wdata[pick*DATA_W +: DATA_W];
            mem_size <= port_size[pick*2 +: 2];
         end
         if (state == WAIT) begin
            cnt <= cnt + 1'b1;
            // completion beats a coincident timeout
            if (cmp) begin
               port_rdata <= wr ? '0 : mem_rdata;
               port_err <= 1'b0;
            end else if (tmo) begin
               port_rdata <= '0;
               port_err <= 1'b1;
            end
         end
         if (state == DONE) begin
            rr_ptr <= grant == PW'(NUM_PORTS - 1) ? '0 : grant + 1'b1;
            cnt <= '0;
         end
      end
   assign port_done = {{(NUM_PORTS-1){1'b0}}, state == DONE} << grant;
   assign port_continue = ~port_req | port_done;
   assign mem_read_request = state == WAIT && !wr;
   assign mem_write_request = state == WAIT && wr;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int N = 4;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 8;
   logic aclk = 1'b0;
   logic reset;
   logic [N-1:0] port_req, port_write, port_done, port_continue;
   logic [N*AW-1:0] port_addr;
   logic [N*DW-1:0] port_wdata;
   logic [N*2-1:0] port_size;
   logic port_err;
   logic [DW-1:0] port_rdata;
   logic mem_read_request, mem_write_request;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_wdata;
   logic [1:0] mem_size;
   logic mem_read_ready;
   logic [DW-1:0] mem_rdata;
   logic mem_write_finished;
   int n_cmp = 0;
   int n_mis = 0;

   mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .aclk(aclk), .reset(reset),
      .port_req(port_req), .port_write(port_write), .port_addr(port_addr),
      .port_wdata(port_wdata), .port_size(port_size),
      .port_done(port_done), .port_err(port_err), .port_rdata(port_rdata),
      .port_continue(port_continue),
      .mem_read_request(mem_read_request), .mem_write_request(mem_write_request),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_size(mem_size),
      .mem_read_ready(mem_read_ready), .mem_rdata(mem_rdata),
      .mem_write_finished(mem_write_finished)
   );

   always #5 aclk = ~aclk;

   task automatic tick;
      @(negedge aclk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      n_cmp++; if ({mem_read_request, mem_write_request, port_err} !== 3'b000) begin n_mis++; $display("FAIL rst_ctl: got %b exp 000", {mem_read_request, mem_write_request, port_err}); end
      n_cmp++; if (port_done !== 4'b0000) begin n_mis++; $display("FAIL rst_done: got %b exp 0000", port_done); end
      n_cmp++; if (port_continue !== 4'b1111) begin n_mis++; $display("FAIL rst_cont: got %b exp 1111", port_continue); end
      n_cmp++; if (mem_address !== 64'h0 || mem_wdata !== 64'h0 || mem_size !== 2'b00) begin n_mis++; $display("FAIL rst_mem: got %h %h %b exp 0", mem_address, mem_wdata, mem_size); end
      n_cmp++; if (port_rdata !== 64'h0) begin n_mis++; $display("FAIL rst_rdata: got %h exp 0", port_rdata); end
   endtask

   task automatic test_single_read;
      port_addr[AW +: AW] = 64'h1000;
      port_size[2 +: 2] = 2'b11;
      port_write = '0;
      port_req = 4'b0010;
      tick;
      n_cmp++; if (mem_size !== 2'b11) begin n_mis++; $display("FAIL sr_size: got %b exp 11", mem_size); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if ({mem_read_request, mem_write_request} !== 2'b10) begin n_mis++; $display("FAIL sr_req: cyc %0d got %b exp 10", k, {mem_read_request, mem_write_request}); end
         n_cmp++; if (mem_address !== 64'h1000) begin n_mis++; $display("FAIL sr_addr: cyc %0d got %h exp 1000", k, mem_address); end
         n_cmp++; if (port_done !== 4'b0000 || port_continue[1] !== 1'b0) begin n_mis++; $display("FAIL sr_wait: cyc %0d done %b cont %b", k, port_done, port_continue); end
         if (k == 3) begin
            mem_read_ready = 1'b1;
            mem_rdata = 64'hDEADBEEF_CAFEF00D;
         end
         tick;
      end
      mem_read_ready = 1'b0;
      n_cmp++; if (port_done !== 4'b0010) begin n_mis++; $display("FAIL sr_done: got %b exp 0010", port_done); end
      n_cmp++; if (port_rdata !== 64'hDEADBEEF_CAFEF00D || port_err !== 1'b0) begin n_mis++; $display("FAIL sr_data: got %h err %b exp deadbeefcafef00d err 0", port_rdata, port_err); end
      n_cmp++; if (port_continue !== 4'b1111 || mem_read_request !== 1'b0) begin n_mis++; $display("FAIL sr_cont: got %b req %b exp 1111 req 0", port_continue, mem_read_request); end
      port_req = '0;
      tick;
      n_cmp++; if (port_done !== 4'b0000 || port_rdata !== 64'hDEADBEEF_CAFEF00D) begin n_mis++; $display("FAIL sr_hold: done %b rdata %h", port_done, port_rdata); end
   endtask

   task automatic test_timeout;
      port_addr[0 +: AW] = 64'h40;
      port_req = 4'b0001;
      tick;
      for (int k = 0; k < TO; k++) begin
         n_cmp++; if (mem_read_request !== 1'b1 || port_done !== 4'b0000) begin n_mis++; $display("FAIL to_wait: cyc %0d req %b done %b exp 1 0000", k, mem_read_request, port_done); end
         tick;
      end
      n_cmp++; if (port_done !== 4'b0001) begin n_mis++; $display("FAIL to_done: got %b exp 0001", port_done); end
      n_cmp++; if (port_err !== 1'b1 || port_rdata !== 64'h0) begin n_mis++; $display("FAIL to_err: got err %b rdata %h exp 1 0", port_err, port_rdata); end
      port_req = '0;
      tick;
   endtask

   task automatic test_wrong_strobe;
      port_addr[2*AW +: AW] = 64'h2000;
      port_wdata[2*DW +: DW] = 64'h1111_2222_3333_4444;
      port_write = 4'b0100;
      port_req = 4'b0100;
      tick;
      n_cmp++; if ({mem_read_request, mem_write_request} !== 2'b01) begin n_mis++; $display("FAIL ws_req: got %b exp 01", {mem_read_request, mem_write_request}); end
      n_cmp++; if (mem_wdata !== 64'h1111_2222_3333_4444 || mem_address !== 64'h2000) begin n_mis++; $display("FAIL ws_fields: got %h %h", mem_wdata, mem_address); end
      mem_read_ready = 1'b1;
      mem_rdata = 64'hBAD;
      tick;
      mem_read_ready = 1'b0;
      n_cmp++; if (port_done !== 4'b0000 || mem_write_request !== 1'b1) begin n_mis++; $display("FAIL ws_ignore: done %b wreq %b exp 0000 1", port_done, mem_write_request); end
      tick;
      n_cmp++; if (port_done !== 4'b0000 || mem_write_request !== 1'b1) begin n_mis++; $display("FAIL ws_hold: done %b wreq %b exp 0000 1", port_done, mem_write_request); end
      mem_write_finished = 1'b1;
      tick;
      mem_write_finished = 1'b0;
      n_cmp++; if (port_done !== 4'b0100) begin n_mis++; $display("FAIL ws_done: got %b exp 0100", port_done); end
      n_cmp++; if (port_err !== 1'b0 || port_rdata !== 64'h0) begin n_mis++; $display("FAIL ws_data: got err %b rdata %h exp 0 0", port_err, port_rdata); end
      port_req = '0;
      port_write = '0;
      tick;
      mem_read_ready = 1'b1;
      mem_write_finished = 1'b1;
      tick;
      tick;
      n_cmp++; if (port_done !== 4'b0000 || {mem_read_request, mem_write_request} !== 2'b00) begin n_mis++; $display("FAIL ws_idle: done %b req %b exp 0", port_done, {mem_read_request, mem_write_request}); end
      mem_read_ready = 1'b0;
      mem_write_finished = 1'b0;
   endtask

   task automatic test_simultaneous;
      port_addr[3*AW +: AW] = 64'h3000;
      port_req = 4'b1000;
      tick;
      for (int k = 0; k < TO; k++) begin
         n_cmp++; if (port_done !== 4'b0000) begin n_mis++; $display("FAIL sim_wait: cyc %0d got %b exp 0000", k, port_done); end
         if (k == 3) port_req = '0;
         if (k == TO - 1) begin
            mem_read_ready = 1'b1;
            mem_rdata = 64'h0123_4567_89AB_CDEF;
         end
         tick;
      end
      mem_read_ready = 1'b0;
      n_cmp++; if (port_done !== 4'b1000) begin n_mis++; $display("FAIL sim_done: got %b exp 1000", port_done); end
      n_cmp++; if (port_err !== 1'b0 || port_rdata !== 64'h0123_4567_89AB_CDEF) begin n_mis++; $display("FAIL sim_data: got err %b rdata %h exp 0 0123456789abcdef", port_err, port_rdata); end
      tick;
   endtask

   task automatic test_round_robin;
      logic [N-1:0] exp;
      int dones;
      dones = 0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      port_write = 4'b1111;
      port_req = 4'b1111;
      mem_write_finished = 1'b1;
      for (int c = 0; c < 26; c++) begin
         tick;
         if (port_done != 4'b0000) begin
            exp = 4'b0001 << (dones % N);
            n_cmp++; if (port_done !== exp) begin n_mis++; $display("FAIL rr_order: txn %0d got %b exp %b", dones, port_done, exp); end
            n_cmp++; if (port_continue !== exp) begin n_mis++; $display("FAIL rr_cont_done: txn %0d got %b exp %b", dones, port_continue, exp); end
            dones++;
         end else begin
            n_cmp++; if (port_continue !== 4'b0000) begin n_mis++; $display("FAIL rr_cont: cyc %0d got %b exp 0000", c, port_continue); end
         end
      end
      n_cmp++; if (dones !== 9) begin n_mis++; $display("FAIL rr_count: got %0d exp 9", dones); end
      port_req = '0;
      port_write = '0;
      mem_write_finished = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_wait;
      port_req = 4'b0010;
      mem_read_ready = 1'b1;
      tick;
      tick;
      n_cmp++; if (port_done !== 4'b0010) begin n_mis++; $display("FAIL rm_pre: got %b exp 0010", port_done); end
      port_req = '0;
      mem_read_ready = 1'b0;
      tick;
      port_req = 4'b0100;
      tick;
      tick;
      n_cmp++; if (mem_read_request !== 1'b1) begin n_mis++; $display("FAIL rm_wait: got %b exp 1", mem_read_request); end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      port_req = '0;
      n_cmp++; if (mem_read_request !== 1'b0 || port_done !== 4'b0000 || port_rdata !== 64'h0) begin n_mis++; $display("FAIL rm_rst: req %b done %b rdata %h exp 0", mem_read_request, port_done, port_rdata); end
      for (int k = 0; k < 3; k++) begin
         tick;
         n_cmp++; if (port_done !== 4'b0000 || mem_read_request !== 1'b0) begin n_mis++; $display("FAIL rm_quiet: cyc %0d done %b req %b exp 0", k, port_done, mem_read_request); end
      end
      port_addr[0 +: AW] = 64'hA000;
      port_addr[3*AW +: AW] = 64'hD000;
      port_req = 4'b1001;
      tick;
      n_cmp++; if (mem_address !== 64'hA000 || mem_read_request !== 1'b1) begin n_mis++; $display("FAIL rm_grant: addr %h req %b exp a000 1", mem_address, mem_read_request); end
      mem_read_ready = 1'b1;
      mem_rdata = 64'h55;
      tick;
      mem_read_ready = 1'b0;
      n_cmp++; if (port_done !== 4'b0001 || port_rdata !== 64'h55) begin n_mis++; $display("FAIL rm_done: done %b rdata %h exp 0001 55", port_done, port_rdata); end
      port_req = '0;
      tick;
   endtask

   initial begin
      reset = 1'b1;
      port_req = '0;
      port_write = '0;
      port_addr = '0;
      port_wdata = '0;
      port_size = '0;
      mem_read_ready = 1'b0;
      mem_rdata = '0;
      mem_write_finished = 1'b0;
      test_reset;
      test_single_read;
      test_timeout;
      test_wrong_strobe;
      test_simultaneous;
      test_round_robin;
      test_reset_mid_wait;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
